// File: rtl/tx_frontend_if.sv
// Character handshake and frame configuration between the TX holding
// register and the UART transmit frontend.
//
// Handshake: a character moves when valid_i and ready_o are both high at a
// rising clock edge. The master holds valid_i, data_i and the configuration
// stable until that edge. ready_o does not depend combinationally on valid_i.
interface tx_frontend_if;
    logic [15:0] clk_div_i;
    logic        ds_i;
    logic        p_i;
    logic        pt_i;
    logic        s_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;

    modport master (
        output clk_div_i, ds_i, p_i, pt_i, s_i, data_i, valid_i,
        input  ready_o
    );

    modport slave (
        input  clk_div_i, ds_i, p_i, pt_i, s_i, data_i, valid_i,
        output ready_o
    );
endinterface

// File: rtl/tx_frontend.sv
// UART transmit frontend: takes one character per handshake and shifts it out
// as start bit, 7/8 data bits LSB first, optional parity and 1/2 stop bits.
// Every bit lasts max(clk_div, 1) clock cycles. uart_tx_o comes straight
// from a flop.
module tx_frontend (
    input  logic                 clk_i,
    input  logic                 rst_i,
    tx_frontend_if.slave         bus,
    output logic                 uart_tx_o,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        stop_q, stop_d;
    logic [7:0]  data_q, data_d;
    logic        ds_q, ds_d;
    logic        p_q, p_d;
    logic        pt_q, pt_d;
    logic        s_q, s_d;
    logic [15:0] div_q, div_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;

    logic [15:0] div_in;
    logic [15:0] reload;
    logic [2:0]  last_idx;
    logic        bit_done;
    logic        parity_bit;

    // Divisor of zero behaves like one so every bit lasts at least one cycle.
    assign div_in   = (bus.clk_div_i == 16'd0) ? 16'd1 : bus.clk_div_i;
    assign reload   = div_q - 16'd1;
    assign last_idx = ds_q ? 3'd7 : 3'd6;
    assign bit_done = (cnt_q == 16'd0);

    // State register plus all datapath flops; reset aborts any frame in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            stop_q  <= 1'b0;
            data_q  <= 8'd0;
            ds_q    <= 1'b0;
            p_q     <= 1'b0;
            pt_q    <= 1'b0;
            s_q     <= 1'b0;
            div_q   <= 16'd1;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            ds_q    <= ds_d;
            p_q     <= p_d;
            pt_q    <= pt_d;
            s_q     <= s_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    // Next state, bit timing and the line level that belongs to the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        data_d  = data_q;
        ds_d    = ds_q;
        p_d     = p_q;
        pt_d    = pt_q;
        s_d     = s_q;
        div_d   = div_q;

        case (state_q)
            IDLE: begin
                if (bus.valid_i && ready_q) begin
                    data_d  = bus.data_i;
                    ds_d    = bus.ds_i;
                    p_d     = bus.p_i;
                    pt_d    = bus.pt_i;
                    s_d     = bus.s_i;
                    div_d   = div_in;
                    cnt_d   = div_in - 16'd1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    cnt_d   = reload;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = reload;
                    if (idx_q == last_idx) begin
                        stop_d  = 1'b0;
                        state_d = p_q ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    stop_d  = 1'b0;
                    cnt_d   = reload;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    // Second stop bit reuses the counter instead of a 2*D load.
                    if (s_q && !stop_q) begin
                        stop_d = 1'b1;
                        cnt_d  = reload;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        parity_bit = (^data_d[6:0]) ^ (ds_d & data_d[7]) ^ pt_d;

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = parity_bit;
            default: tx_d = 1'b1;
        endcase

        ready_d = (state_d == IDLE);
    end

    assign bus.ready_o = ready_q;
    assign uart_tx_o   = tx_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/tx_frontend.md
Name: tx_frontend

Overview:
UART transmit frontend; the transmit counterpart of the rx_frontend receiver in ECAP5-DWBUART. Accepts one character at a time through a valid/ready handshake and serialises it onto uart_tx_o: start bit, 7 or 8 data bits LSB first, optional parity, 1 or 2 stop bits. Bit timing comes from the same clk_div_i divisor the receiver uses. Sits between the Wishbone register front (TX holding register) and the pad.

Parameters:
none (frame format is runtime-configured through ports)

Ports:
clk_i       input   1    system clock, all logic on rising edge
rst_i       input   1    reset, synchronous, active-low
clk_div_i   input   16   clock cycles per UART bit; 0 treated as 1
ds_i        input   1    data size: 0 = 7 bits, 1 = 8 bits
p_i         input   1    parity enable
pt_i        input   1    parity type: 0 = even, 1 = odd
s_i         input   1    stop bits: 0 = one, 1 = two
data_i      input   8    character to send; bit 7 ignored when ds_i = 0
valid_i     input   1    data_i and config valid
ready_o     output  1    frontend can accept a character
uart_tx_o   output  1    serial line, idle high

Behaviour:
- Reset (rst_i = 0 at a clock edge): state IDLE, uart_tx_o = 1, ready_o = 1, counters cleared. Applies mid-frame: the frame is aborted and the line returns high on the next cycle, no partial bits resumed.
- ready_o = 1 exactly when state = IDLE; registered output.
- Handshake: transfer when valid_i & ready_o at a clock edge. On transfer, latch data_i, ds_i, p_i, pt_i, s_i and D = max(clk_div_i, 1). Inputs changing after the transfer have no effect on the current frame.
- valid_i high while ready_o low is ignored: no queuing, and data is not dropped silently. The upstream must hold valid_i until it sees ready_o.
- FSM states: IDLE -> START -> DATA -> (PARITY if p) -> STOP -> IDLE.
- Every bit state holds uart_tx_o for exactly D cycles, counted by a 16-bit down-counter reloaded with D-1 on each bit entry. The transition happens when the counter = 0.
- START drives 0. It begins on the cycle after the transfer: the first uart_tx_o = 0 is visible one cycle after the accepting edge.
- DATA drives latched data bit i, i = 0..n-1, with n = 7 or 8. A 3-bit index is incremented per bit; leave DATA when index = n-1 and the counter = 0.
- PARITY drives XOR of the n data bits, inverted when pt = 1 (odd).
- STOP drives 1 for D cycles, or 2·D cycles when s = 1. A stop-bit count is used, not a doubled counter, so D = 0xFFFF does not overflow.
- Frame length = D·(1 + n + p + 1 + s) cycles from the first start cycle. After the last stop cycle the FSM enters IDLE and ready_o = 1.
- Back-to-back frames: a transfer in that IDLE cycle means at least one extra high cycle between frames. This is acceptable because the line is already at the stop level.
- uart_tx_o is driven directly from a flop (no combinational glitches to the pad). It is 1 in IDLE.
- clk_div_i = 1: one cycle per bit, full-rate operation must work.

Test Plan:
- Basic 8N1: rst, clk_div_i=4, ds=1, p=0, s=0, data_i=0xA5, valid_i pulse -> ready_o drops next cycle. uart_tx_o pattern per 4 cycles: 0,1,0,1,0,0,1,0,1,1 (40 cycles). ready_o = 1 in the cycle after the last stop cycle.
- Parity: clk_div=2, data 0xA5, p=1, pt=0 -> parity bit 0. With pt=1 -> parity bit 1. Frame = 22 cycles.
- 7-bit + 2 stop: clk_div=3, ds=0, p=1, pt=0, s=1, data_i=0xFF -> 7 ones, parity 1, stop high for 6 cycles. Bit 7 is never sent. Frame = 33 cycles.
- Handshake/config stability: hold valid_i=1 with changing data_i during a frame -> only the first value is sent. Second character accepted only when ready_o=1; data_i/clk_div_i changes mid-frame do not alter bit timing or data.
- Divisor edges: clk_div_i=0 and 1 -> identical 1-cycle bits. clk_div_i=0xFFFF start bit lasts exactly 65535 cycles (spot-check counter, no overflow).
- Reset mid-frame: assert rst_i=0 during DATA bit 3 -> uart_tx_o = 1 and ready_o = 1 next cycle. New 0x3C frame afterwards is sent correctly.
